snn_timestep_scheduler: RTL and testbench
=========================================

# snn_timestep_scheduler

Sequencer for the spiking-neural-network datapath in the user project area. After a start pulse, it walks every timestep, output neuron and input neuron. It reads input spikes, fetches synaptic weights through a request/grant memory port, and issues accumulate and leak/fire commands to the neuron datapath. It is driven from the Wishbone configuration registers and runs on the Wishbone clock.

## Interface
- Parameters:
  - IDX_W, 8: neuron index width (max 2^IDX_W inputs/outputs)
  - T_W, 8: timestep counter width
  - ADDR_W, 16: weight memory address width
  - WEIGHT_W, 8: signed weight width
- Ports:
  - wb_clk_i  in  1  clock; the only clock
  - wb_rst_i  in  1  reset; synchronous, active-high
  - start  in  1  one-cycle start pulse; ignored while busy
  - cfg_num_in  in  IDX_W  input neuron count
  - cfg_num_out  in  IDX_W  output neuron count
  - cfg_timesteps  in  T_W  timestep count
  - busy  out  1  high from the cycle after accepted start until done
  - done  out  1  one-cycle pulse at completion
  - spk_t  out  T_W  input spike read timestep
  - spk_idx  out  IDX_W  input spike read index
  - spk_bit  in  1  spike bit; valid one cycle after address
  - w_req  out  1  weight read request; held until w_gnt
  - w_addr  out  ADDR_W  weight address; stable while w_req
  - w_gnt  in  1  arbiter grant
  - w_rvalid  in  1  read data valid
  - w_rdata  in  WEIGHT_W  weight data
  - np_valid  out  1  datapath command strobe
  - np_op  out  1  0 = ACC, 1 = LEAK_FIRE
  - np_idx  out  IDX_W  target output neuron
  - np_weight  out  WEIGHT_W  weight for ACC; 0 for LEAK_FIRE
  - np_fire  in  1  fire result, combinational, same cycle as LEAK_FIRE
  - out_spk_we  out  1  output spike write
  - out_spk_t  out  T_W  output spike timestep
  - out_spk_idx  out  IDX_W  output spike index

## Operation
- Configuration is latched when start is accepted in IDLE; later changes have no effect until the next run.
- States:
  - IDLE
  - RD_SPK: drive spk_t/spk_idx
  - CHK: sample spk_bit
  - FETCH: w_req high until w_gnt
  - WAIT: wait for w_rvalid
  - ACC: np_valid, op 0, np_weight = captured w_rdata
  - NEXT_IN
  - LEAK: np_valid, op 1; if np_fire, out_spk_we=1 in the same cycle
  - NEXT_OUT
  - NEXT_T
  - DONE: done=1, then IDLE
- Loop order: t outermost, then output neuron o, then input neuron i.
- Weight address: w_addr = o*cfg_num_in + i, truncated to ADDR_W.
  - Produced by a running base pointer; no multiplier.
  - The base is reset to 0 at each new timestep.
- Input loop: NEXT_IN increments i. It goes to RD_SPK if i+1 < cfg_num_in, else to LEAK.
- Degenerate configurations:
  - cfg_num_in=0: each output neuron goes directly to LEAK.
  - cfg_num_out=0 or cfg_timesteps=0: IDLE → DONE, no other strobes.
- w_rvalid outside WAIT is ignored. w_gnt with w_req low is ignored.
- Counters are wide enough that i, o and t never wrap within a legal run.
- wb_rst_i mid-run forces IDLE in the next cycle. All strobes are dropped and no done pulse is produced; an outstanding weight read is abandoned.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - busy, done, w_req, np_valid, out_spk_we low.
- start accepted at cycle N: busy=1 and RD_SPK at N+1.
- Per input, spike zero (skip enabled): 2 cycles (RD_SPK, CHK).
- Per input, fetched: 2 cycles + FETCH (≥1) + WAIT (≥1) + ACC (1). With immediate grant and rvalid one cycle later, that is 5 cycles.
- LEAK, NEXT_OUT and NEXT_T are 1 cycle each. NEXT_IN shares its cycle with the following decision.
- done pulses for exactly 1 cycle. busy falls in the same cycle done rises.
- Control outputs (np_*, w_*, out_spk_*) are registered. np_fire and spk_bit are the only combinational inputs used in-cycle.

## Configuration
- SNN_SKIP_ZERO_EN defined: CHK with spk_bit=0 skips FETCH/WAIT/ACC and goes to NEXT_IN. No memory traffic for silent inputs.
- SNN_SKIP_ZERO_EN undefined:
  - Every input is fetched and accumulated.
  - np_weight = spk_bit ? w_rdata : 0.
  - Cycle count is independent of spike data.

## Test plan
- Config in=4, out=2, T=1; all spikes 0; np_fire=0:
  - Skip enabled: 0 w_req; 2 LEAK strobes; done once.
  - Skip disabled: 8 w_req with addresses 0..7 in order; 8 ACC strobes, all with weight 0.
- Config in=3, out=1, T=2; spikes 1; w_rdata = address+1; np_fire=1 on LEAK → ACC weights 1,2,3 in each timestep; out_spk_we at (t0,o0) and (t1,o0).
- Grant stall: w_gnt held low 5 cycles → w_req and w_addr stable for 5 cycles; exactly one ACC follows the grant.
- Degenerate: in=0, out=3, T=1 → 3 LEAK strobes, no w_req. out=0 → done 2 cycles after start, no np_valid.
- Reset mid-run: assert wb_rst_i during WAIT → next cycle all outputs 0 and busy=0, no done. A new start runs the full sequence from t=0.
- Start while busy → ignored; the latched configuration is unchanged and exactly one done pulse occurs.

Source files
------------

// File: rtl/snn_timestep_scheduler.sv
// Timestep / output-neuron / input-neuron sequencer feeding the SNN neuron datapath.
// Optional build macro SNN_SKIP_ZERO_EN: skip weight fetch and ACC for silent input spikes.
module snn_timestep_scheduler #(
    parameter int IDX_W    = 8,
    parameter int T_W      = 8,
    parameter int ADDR_W   = 16,
    parameter int WEIGHT_W = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start,
    input  logic [IDX_W-1:0]    cfg_num_in,
    input  logic [IDX_W-1:0]    cfg_num_out,
    input  logic [T_W-1:0]      cfg_timesteps,
    output logic                busy,
    output logic                done,
    output logic [T_W-1:0]      spk_t,
    output logic [IDX_W-1:0]    spk_idx,
    input  logic                spk_bit,
    output logic                w_req,
    output logic [ADDR_W-1:0]   w_addr,
    input  logic                w_gnt,
    input  logic                w_rvalid,
    input  logic [WEIGHT_W-1:0] w_rdata,
    output logic                np_valid,
    output logic                np_op,
    output logic [IDX_W-1:0]    np_idx,
    output logic [WEIGHT_W-1:0] np_weight,
    input  logic                np_fire,
    output logic                out_spk_we,
    output logic [T_W-1:0]      out_spk_t,
    output logic [IDX_W-1:0]    out_spk_idx
);

    // state      | meaning
    // S_IDLE     | wait for start, latch configuration
    // S_RD_SPK   | drive input spike address
    // S_CHK      | sample spk_bit; input-advance decision folded in
    // S_FETCH    | hold w_req until w_gnt
    // S_WAIT     | wait for w_rvalid
    // S_ACC      | ACC command; input-advance decision folded in
    // S_LEAK     | LEAK_FIRE command, output spike write on np_fire
    // S_NEXT_OUT | advance output neuron and weight base
    // S_NEXT_T   | advance timestep, clear weight base
    // S_DONE     | completion; done pulses on the following cycle
    typedef enum logic [3:0] {
        S_IDLE, S_RD_SPK, S_CHK, S_FETCH, S_WAIT, S_ACC,
        S_LEAK, S_NEXT_OUT, S_NEXT_T, S_DONE
    } state_t;

`ifdef SNN_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    state_t state, state_nx, out_entry;

    logic [IDX_W-1:0]  in_q, out_q, i_cnt, o_cnt;
    logic [T_W-1:0]    t_q, t_cnt;
    logic [ADDR_W-1:0] base;
    logic              spk_q;
    logic              in_more, out_more, t_more;

    // Counts never exceed their latched limits, so the +1 cannot wrap.
    assign in_more   = (i_cnt + IDX_W'(1)) < in_q;
    assign out_more  = (o_cnt + IDX_W'(1)) < out_q;
    assign t_more    = (t_cnt + T_W'(1)) < t_q;
    assign out_entry = (in_q == '0) ? S_LEAK : S_RD_SPK;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_num_out == '0 || cfg_timesteps == '0) state_nx = S_DONE;
                    else if (cfg_num_in == '0)                    state_nx = S_LEAK;
                    else                                          state_nx = S_RD_SPK;
                end
            end
            S_RD_SPK:   state_nx = S_CHK;
            S_CHK: begin
                if (SKIP_ZERO && !spk_bit) state_nx = in_more ? S_RD_SPK : S_LEAK;
                else                       state_nx = S_FETCH;
            end
            S_FETCH:    if (w_gnt)    state_nx = S_WAIT;
            S_WAIT:     if (w_rvalid) state_nx = S_ACC;
            S_ACC:      state_nx = in_more ? S_RD_SPK : S_LEAK;
            S_LEAK:     state_nx = S_NEXT_OUT;
            S_NEXT_OUT: state_nx = out_more ? out_entry : S_NEXT_T;
            S_NEXT_T:   state_nx = t_more ? out_entry : S_DONE;
            S_DONE:     state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            in_q      <= '0;
            out_q     <= '0;
            t_q       <= '0;
            i_cnt     <= '0;
            o_cnt     <= '0;
            t_cnt     <= '0;
            base      <= '0;
            spk_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            w_req     <= 1'b0;
            w_addr    <= '0;
            np_valid  <= 1'b0;
            np_op     <= 1'b0;
            np_weight <= '0;
        end else begin
            state    <= state_nx;
            busy     <= (state_nx != S_IDLE);
            done     <= (state == S_DONE);
            w_req    <= (state_nx == S_FETCH);
            np_valid <= (state_nx == S_ACC) || (state_nx == S_LEAK);
            np_op    <= (state_nx == S_LEAK);

            if (state == S_IDLE && start) begin
                in_q  <= cfg_num_in;
                out_q <= cfg_num_out;
                t_q   <= cfg_timesteps;
                i_cnt <= '0;
                o_cnt <= '0;
                t_cnt <= '0;
                base  <= '0;
            end

            if (state == S_CHK) spk_q <= spk_bit;
            if (state == S_CHK && state_nx == S_FETCH) w_addr <= base + ADDR_W'(i_cnt);

            // Without skipping, a silent input still costs a fetch but contributes zero.
            if (state == S_WAIT && w_rvalid)
                np_weight <= (spk_q || SKIP_ZERO) ? w_rdata : '0;
            else if (state_nx == S_LEAK)
                np_weight <= '0;

            if ((state == S_CHK && state_nx != S_FETCH) || state == S_ACC)
                i_cnt <= in_more ? i_cnt + IDX_W'(1) : '0;

            if (state == S_NEXT_OUT) begin
                if (out_more) begin
                    o_cnt <= o_cnt + IDX_W'(1);
                    base  <= base + ADDR_W'(in_q);
                end else begin
                    o_cnt <= '0;
                end
            end

            if (state == S_NEXT_T) begin
                base <= '0;
                if (t_more) t_cnt <= t_cnt + T_W'(1);
            end
        end
    end

    assign spk_t       = t_cnt;
    assign spk_idx     = i_cnt;
    assign np_idx      = o_cnt;
    assign out_spk_t   = t_cnt;
    assign out_spk_idx = o_cnt;
    assign out_spk_we  = np_valid & np_op & np_fire;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Scoreboard bench for snn_timestep_scheduler: directed runs push expected events,
// a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_snn_timestep_scheduler;
    localparam int IDX_W    = 8;
    localparam int T_W      = 8;
    localparam int ADDR_W   = 16;
    localparam int WEIGHT_W = 8;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_i = 1'b1;
    logic                start = 1'b0;
    logic [IDX_W-1:0]    cfg_num_in = '0;
    logic [IDX_W-1:0]    cfg_num_out = '0;
    logic [T_W-1:0]      cfg_timesteps = '0;
    logic                busy, done, w_req, np_valid, np_op, out_spk_we;
    logic [T_W-1:0]      spk_t, out_spk_t;
    logic [IDX_W-1:0]    spk_idx, np_idx, out_spk_idx;
    logic [ADDR_W-1:0]   w_addr;
    logic [WEIGHT_W-1:0] np_weight;
    logic                spk_bit = 1'b0;
    logic                w_gnt = 1'b0;
    logic                w_rvalid = 1'b0;
    logic [WEIGHT_W-1:0] w_rdata = '0;
    logic                np_fire = 1'b0;

    snn_timestep_scheduler #(
        .IDX_W(IDX_W), .T_W(T_W), .ADDR_W(ADDR_W), .WEIGHT_W(WEIGHT_W)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start),
        .cfg_num_in(cfg_num_in), .cfg_num_out(cfg_num_out), .cfg_timesteps(cfg_timesteps),
        .busy(busy), .done(done), .spk_t(spk_t), .spk_idx(spk_idx), .spk_bit(spk_bit),
        .w_req(w_req), .w_addr(w_addr), .w_gnt(w_gnt), .w_rvalid(w_rvalid), .w_rdata(w_rdata),
        .np_valid(np_valid), .np_op(np_op), .np_idx(np_idx), .np_weight(np_weight),
        .np_fire(np_fire), .out_spk_we(out_spk_we), .out_spk_t(out_spk_t),
        .out_spk_idx(out_spk_idx)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {
        logic                op;
        logic [IDX_W-1:0]    idx;
        logic [WEIGHT_W-1:0] w;
    } np_t;

    np_t                     exp_np[$];
    logic [ADDR_W-1:0]       exp_w[$];
    logic [T_W+IDX_W-1:0]    exp_out[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int gnt_delay = 0;
    bit spk_all = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected strobe with value %0d, none expected (t=%0t)", name, act, $time);
    endtask

    function automatic void push_acc(input int idx, input int w);
        np_t e;
        e.op = 1'b0; e.idx = IDX_W'(idx); e.w = WEIGHT_W'(w);
        exp_np.push_back(e);
    endfunction

    function automatic void push_leak(input int idx);
        np_t e;
        e.op = 1'b1; e.idx = IDX_W'(idx); e.w = '0;
        exp_np.push_back(e);
    endfunction

    function automatic void push_out(input int t, input int idx);
        exp_out.push_back({T_W'(t), IDX_W'(idx)});
    endfunction

    initial forever begin
        @(posedge wb_clk_i);
        cyc++;
    end

    // Spike memory (registered read) and weight memory arbiter: data = address + 1.
    initial begin
        int stall;
        bit pend;
        logic [ADDR_W-1:0] raddr;
        stall = 0; pend = 1'b0; raddr = '0;
        forever begin
            @(posedge wb_clk_i);
            #1;
            spk_bit  = spk_all;
            w_gnt    = 1'b0;
            w_rvalid = 1'b0;
            if (pend) begin
                w_rvalid = 1'b1;
                w_rdata  = WEIGHT_W'(raddr + ADDR_W'(1));
                pend     = 1'b0;
            end else if (w_req === 1'b1) begin
                if (stall < gnt_delay) stall++;
                else begin
                    w_gnt = 1'b1;
                    raddr = w_addr;
                    pend  = 1'b1;
                    stall = 0;
                end
            end
        end
    end

    initial begin
        int run;
        np_t e;
        logic [T_W+IDX_W-1:0] o;
        run = 0;
        forever begin
            @(negedge wb_clk_i);
            if (w_req === 1'b1) begin
                run++;
                if (exp_w.size() == 0) unexpected("w_req", 64'(w_addr));
                else chk("w_addr", 64'(w_addr), 64'(exp_w[0]));
                if (w_gnt) begin
                    chk("w_req_hold_cycles", 64'(run), 64'(gnt_delay + 1));
                    if (exp_w.size() != 0) void'(exp_w.pop_front());
                    run = 0;
                end
            end else begin
                run = 0;
            end
            if (np_valid === 1'b1) begin
                if (exp_np.size() == 0) unexpected("np_valid", 64'({np_op, np_idx}));
                else begin
                    e = exp_np.pop_front();
                    chk("np_op", 64'(np_op), 64'(e.op));
                    chk("np_idx", 64'(np_idx), 64'(e.idx));
                    chk("np_weight", 64'(np_weight), 64'(e.w));
                end
            end
            if (out_spk_we === 1'b1) begin
                if (exp_out.size() == 0) unexpected("out_spk_we", 64'({out_spk_t, out_spk_idx}));
                else begin
                    o = exp_out.pop_front();
                    chk("out_spk_t", 64'(out_spk_t), 64'(o[T_W+IDX_W-1:IDX_W]));
                    chk("out_spk_idx", 64'(out_spk_idx), 64'(o[IDX_W-1:0]));
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_low_at_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_w_req"}, 64'(w_req), 64'd0);
        chk({tag, "_w_addr"}, 64'(w_addr), 64'd0);
        chk({tag, "_np_valid"}, 64'(np_valid), 64'd0);
        chk({tag, "_np_op"}, 64'(np_op), 64'd0);
        chk({tag, "_np_weight"}, 64'(np_weight), 64'd0);
        chk({tag, "_np_idx"}, 64'(np_idx), 64'd0);
        chk({tag, "_out_spk_we"}, 64'(out_spk_we), 64'd0);
        chk({tag, "_spk_t"}, 64'(spk_t), 64'd0);
        chk({tag, "_spk_idx"}, 64'(spk_idx), 64'd0);
    endtask

    // Expectations must be pushed before calling; lat = cycles from start to done.
    task automatic run_test(input string name, input int n_in, input int n_out, input int n_t,
                            input int lat, input bit poke);
        int base_done, st_cyc;
        bit got;
        cfg_num_in    = IDX_W'(n_in);
        cfg_num_out   = IDX_W'(n_out);
        cfg_timesteps = T_W'(n_t);
        @(posedge wb_clk_i);
        #1;
        base_done = done_cnt;
        start  = 1'b1;
        st_cyc = cyc;
        @(posedge wb_clk_i);
        #1;
        start = 1'b0;
        chk({name, "_busy_rise"}, 64'(busy), 64'd1);
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            if (poke && k == 4) begin
                start = 1'b1;
                cfg_num_in = IDX_W'(1); cfg_num_out = IDX_W'(5); cfg_timesteps = T_W'(3);
            end
            if (poke && k == 5) start = 1'b0;
            if (done_cnt != base_done) got = 1'b1;
            else begin
                @(posedge wb_clk_i);
                #1;
            end
        end
        start = 1'b0;
        if (!got) unexpected({name, "_done_timeout"}, 64'(cyc - st_cyc));
        else chk({name, "_latency"}, 64'(done_cyc - st_cyc), 64'(lat));
        repeat (6) @(posedge wb_clk_i);
        #1;
        chk({name, "_done_count"}, 64'(done_cnt - base_done), 64'd1);
        chk({name, "_busy_end"}, 64'(busy), 64'd0);
        chk({name, "_w_left"}, 64'(exp_w.size()), 64'd0);
        chk({name, "_np_left"}, 64'(exp_np.size()), 64'd0);
        chk({name, "_out_left"}, 64'(exp_out.size()), 64'd0);
        exp_w.delete(); exp_np.delete(); exp_out.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_done;
        wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        check_zero("reset");

        // All spikes silent: in=4, out=2, T=1
        spk_all = 1'b0; np_fire = 1'b0; gnt_delay = 0;
`ifdef SNN_SKIP_ZERO_EN
        push_leak(0); push_leak(1);
        run_test("silent", 4, 2, 1, 23, 1'b0);
`else
        for (int o = 0; o < 2; o++) begin
            for (int i = 0; i < 4; i++) begin
                exp_w.push_back(ADDR_W'(o * 4 + i));
                push_acc(o, 0);
            end
            push_leak(o);
        end
        run_test("silent", 4, 2, 1, 47, 1'b0);
`endif

        // All spikes set, firing: in=3, out=1, T=2
        spk_all = 1'b1; np_fire = 1'b1;
        for (int t = 0; t < 2; t++) begin
            exp_w.push_back(16'd0); exp_w.push_back(16'd1); exp_w.push_back(16'd2);
            push_acc(0, 1); push_acc(0, 2); push_acc(0, 3); push_leak(0); push_out(t, 0);
        end
        run_test("fire", 3, 1, 2, 38, 1'b0);

        // Grant stall of 5 cycles on every fetch, base pointer across outputs
        np_fire = 1'b0; gnt_delay = 5;
        exp_w.push_back(16'd0); exp_w.push_back(16'd1); exp_w.push_back(16'd2); exp_w.push_back(16'd3);
        push_acc(0, 1); push_acc(0, 2); push_leak(0);
        push_acc(1, 3); push_acc(1, 4); push_leak(1);
        run_test("stall", 2, 2, 1, 47, 1'b0);
        gnt_delay = 0;

        // No inputs: straight to LEAK per output neuron
        np_fire = 1'b1;
        push_leak(0); push_leak(1); push_leak(2);
        push_out(0, 0); push_out(0, 1); push_out(0, 2);
        run_test("no_inputs", 0, 3, 1, 9, 1'b0);

        run_test("no_outputs", 4, 0, 3, 2, 1'b0);
        run_test("no_timesteps", 2, 2, 0, 2, 1'b0);

        // Reset while waiting for read data
        np_fire = 1'b0;
        cfg_num_in = IDX_W'(2); cfg_num_out = IDX_W'(1); cfg_timesteps = T_W'(1);
        exp_w.push_back(16'd0);
        @(posedge wb_clk_i);
        #1;
        base_done = done_cnt;
        start = 1'b1;
        @(posedge wb_clk_i);
        #1;
        start = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        check_zero("midrun_reset");
        repeat (6) @(posedge wb_clk_i);
        #1;
        chk("midrun_reset_no_done", 64'(done_cnt - base_done), 64'd0);
        chk("midrun_reset_w_left", 64'(exp_w.size()), 64'd0);
        chk("midrun_reset_np_left", 64'(exp_np.size()), 64'd0);
        exp_w.delete();

        np_fire = 1'b1;
        exp_w.push_back(16'd0); exp_w.push_back(16'd1);
        push_acc(0, 1); push_acc(0, 2); push_leak(0); push_out(0, 0);
        run_test("restart", 2, 1, 1, 15, 1'b0);

        // Start pulse with new configuration while busy must be ignored
        np_fire = 1'b0;
        exp_w.push_back(16'd0); exp_w.push_back(16'd1); exp_w.push_back(16'd2);
        push_acc(0, 1); push_acc(0, 2); push_acc(0, 3); push_leak(0);
        run_test("start_busy", 3, 1, 1, 20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
